// File: rtl/frame_buffer_pp.sv
// frame_buffer_pp: ping-pong frame store for an NxNxN LED cube with source select,
// built-in static/sweep patterns and accepted/dropped frame statistics.
module frame_buffer_pp #(
    parameter int N    = 8,
    parameter int NSRC = 2,
    parameter int HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            display_mode,
    input  logic [3:0]            display_sel,
    input  logic [NSRC*N*N*N-1:0] src_frame_flat,
    input  logic [NSRC-1:0]       src_valid,
    input  logic                  scan_done,
    output logic [N*N*N-1:0]      frame_cube_flat,
    output logic                  swap_pending,
    output logic [31:0]           frame_cnt,
    output logic [15:0]           drop_cnt
);
    localparam int FW = N * N * N;
    localparam int IW = $clog2(N);

    logic [FW-1:0]    front_q, front_d, back_q, back_d;
    logic             pending_q, pending_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [IW-1:0]    sweep_idx_q, sweep_idx_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [1:0]       mode_q;
    logic [3:0]       sel_q;
    logic [15:0]      valid_x;
    logic [16*FW-1:0] frames_x;
    logic             changed, is_static, in_range, accept, swap, sweep_on;

    function automatic logic [FW-1:0] gen_pattern(input logic [3:0] sel, input logic [IW-1:0] idx);
        logic [FW-1:0] p;
        logic ex, ey, ez;
        p = '0;
        for (int z = 0; z < N; z++)
            for (int y = 0; y < N; y++)
                for (int x = 0; x < N; x++) begin
                    ex = (x == 0) || (x == N - 1);
                    ey = (y == 0) || (y == N - 1);
                    ez = (z == 0) || (z == N - 1);
                    p[z*N*N + y*N + x] = (sel == 4'd0) ? 1'b1 :
                                         (sel == 4'd2) ? (2'(ex) + 2'(ey) + 2'(ez) >= 2'd2) :
                                         (sel == 4'd3) ? (z == int'(idx)) :
                                         (sel == 4'd4) ? (x == int'(idx)) :
                                         (sel == 4'd5) ? (y == int'(idx)) : 1'b0;
                end
        return p;
    endfunction

    always_comb begin
        valid_x = '0;
        valid_x[NSRC-1:0] = src_valid;
        frames_x = '0;
        frames_x[NSRC*FW-1:0] = src_frame_flat;
        // A mode/sel change discards pending content and suppresses everything else that cycle
        changed   = (display_mode != mode_q) || (display_sel != sel_q);
        is_static = display_mode == 2'd0;
        in_range  = {1'b0, display_sel} < 5'(NSRC);
        accept    = display_mode == 2'd1 && in_range && valid_x[display_sel] && !changed;
        swap      = scan_done && pending_q && !changed;
        sweep_on  = is_static && display_sel >= 4'd3 && display_sel <= 4'd5;
        front_d   = swap ? back_q : front_q;
        back_d    = changed ? back_q :
                    is_static ? gen_pattern(display_sel, sweep_idx_q) :
                    accept ? frames_x[display_sel*FW +: FW] : back_q;
        pending_d = changed ? 1'b0 : is_static ? 1'b1 : swap ? accept : (accept || pending_q);
        frame_cnt_d = frame_cnt_q + 32'(accept);
        drop_cnt_d  = drop_cnt_q + 16'(accept && pending_q && !swap && drop_cnt_q != 16'hFFFF);
        hold_cnt_d  = changed ? 8'd0 :
                      (sweep_on && scan_done) ? (hold_cnt_q == 8'(HOLD - 1) ? 8'd0 : hold_cnt_q + 8'd1) :
                      hold_cnt_q;
        sweep_idx_d = changed ? '0 :
                      (sweep_on && scan_done && hold_cnt_q == 8'(HOLD - 1)) ?
                      (sweep_idx_q == IW'(N - 1) ? '0 : sweep_idx_q + 1'b1) : sweep_idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            front_q     <= '0;
            back_q      <= '0;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            sweep_idx_q <= '0;
            hold_cnt_q  <= '0;
            mode_q      <= '0;
            sel_q       <= '0;
        end else begin
            front_q     <= front_d;
            back_q      <= back_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            sweep_idx_q <= sweep_idx_d;
            hold_cnt_q  <= hold_cnt_d;
            mode_q      <= display_mode;
            sel_q       <= display_sel;
        end
    end

    assign frame_cube_flat = front_q;
    assign swap_pending    = pending_q;
    assign frame_cnt       = frame_cnt_q;
    assign drop_cnt        = drop_cnt_q;
endmodule

// File: tb/tb_frame_buffer_pp.sv
// tb_frame_buffer_pp: directed checks of two frame_buffer_pp configurations
// (N=8/NSRC=2 and N=4/NSRC=3, both with HOLD=2).
module tb_frame_buffer_pp;
    localparam int FW8 = 512;
    localparam int FW4 = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] m8, m4;
    logic [3:0] s8, s4;
    logic [2*FW8-1:0] f8;
    logic [3*FW4-1:0] f4;
    logic [1:0] v8;
    logic [2:0] v4;
    logic sd8, sd4;
    logic [FW8-1:0] q8, e8;
    logic [FW4-1:0] q4, e4;
    logic p8, p4;
    logic [31:0] fc8, fc4;
    logic [15:0] dc8, dc4;
    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    frame_buffer_pp #(.N(8), .NSRC(2), .HOLD(2)) u8 (
        .clk(clk), .rst(rst), .display_mode(m8), .display_sel(s8),
        .src_frame_flat(f8), .src_valid(v8), .scan_done(sd8),
        .frame_cube_flat(q8), .swap_pending(p8), .frame_cnt(fc8), .drop_cnt(dc8)
    );

    frame_buffer_pp #(.N(4), .NSRC(3), .HOLD(2)) u4 (
        .clk(clk), .rst(rst), .display_mode(m4), .display_sel(s4),
        .src_frame_flat(f4), .src_valid(v4), .scan_done(sd4),
        .frame_cube_flat(q4), .swap_pending(p4), .frame_cnt(fc4), .drop_cnt(dc4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset both DUTs, then absorb the mode/sel change cycle so the new mode is live.
    task automatic rst_to(input logic [1:0] mm8, input logic [3:0] ss8,
                          input logic [1:0] mm4, input logic [3:0] ss4);
        rst = 1'b1; m8 = mm8; s8 = ss8; m4 = mm4; s4 = ss4;
        v8 = '0; v4 = '0; sd8 = 1'b0; sd4 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        m8 = 2'($urandom); s8 = 4'($urandom); v8 = 2'($urandom); sd8 = 1'($urandom);
        m4 = 2'($urandom); s4 = 4'($urandom); v4 = 3'($urandom); sd4 = 1'($urandom);
        for (int i = 0; i < 2*FW8/32; i++) f8[i*32 +: 32] = $urandom;
        for (int i = 0; i < 3*FW4/32; i++) f4[i*32 +: 32] = $urandom;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_front8", q8, 0);
        chk("rst_pend8", p8, 0);
        chk("rst_fcnt8", fc8, 0);
        chk("rst_dcnt8", dc8, 0);
        chk("rst_front4", q4, 0);
        chk("rst_pend4", p4, 0);

        // Single frame from source 1
        rst = 1'b0; m8 = 2'd1; s8 = 4'd1; v8 = '0; sd8 = 1'b0; f8 = '0;
        m4 = 2'd2; s4 = 4'd0; v4 = '0; sd4 = 1'b0; f4 = '0;
        tick();
        sd8 = 1'b1; tick(); sd8 = 1'b0;
        chk("noswap_front8", q8, 0);
        f8[FW8 +: FW8] = {64{8'hA5}}; v8 = 2'b10; tick(); v8 = '0;
        chk("single_fcnt", fc8, 1);
        chk("single_pend_hi", p8, 1);
        tick(); tick();
        sd8 = 1'b1; tick(); sd8 = 1'b0;
        chk("single_front", q8, {64{8'hA5}});
        chk("single_pend_lo", p8, 0);
        f8[0 +: FW8] = {64{8'h5A}}; v8 = 2'b01; tick(); v8 = '0;
        chk("unsel_fcnt", fc8, 1);
        chk("unsel_pend", p8, 0);

        // Overwrite before display
        rst_to(2'd1, 4'd0, 2'd2, 4'd0);
        f8[0 +: FW8] = {64{8'hF1}}; v8 = 2'b01; tick();
        f8[0 +: FW8] = {64{8'hF2}}; tick(); v8 = '0;
        chk("ovw_dcnt", dc8, 1);
        chk("ovw_fcnt", fc8, 2);
        chk("ovw_pend", p8, 1);
        sd8 = 1'b1; tick(); sd8 = 1'b0;
        chk("ovw_front", q8, {64{8'hF2}});
        chk("ovw_pend_lo", p8, 0);

        // Collision: valid together with scan_done
        rst_to(2'd1, 4'd0, 2'd2, 4'd0);
        f8[0 +: FW8] = {64{8'hF1}}; v8 = 2'b01; tick();
        f8[0 +: FW8] = {64{8'hF2}}; sd8 = 1'b1; tick(); v8 = '0; sd8 = 1'b0;
        chk("coll_front", q8, {64{8'hF1}});
        chk("coll_pend", p8, 1);
        chk("coll_dcnt", dc8, 0);
        sd8 = 1'b1; tick(); sd8 = 1'b0;
        chk("coll_next_front", q8, {64{8'hF2}});
        chk("coll_next_pend", p8, 0);
        f8[0 +: FW8] = {64{8'h3C}}; v8 = 2'b01; sd8 = 1'b1; tick(); v8 = '0; sd8 = 1'b0;
        chk("coll0_front", q8, {64{8'hF2}});
        chk("coll0_pend", p8, 1);
        chk("coll0_dcnt", dc8, 0);

        // Select change discards the pending frame
        s8 = 4'd1; tick();
        chk("selchg_pend", p8, 0);
        chk("selchg_front", q8, {64{8'hF2}});
        sd8 = 1'b1; tick(); sd8 = 1'b0;
        chk("selchg_scan_front", q8, {64{8'hF2}});
        chk("selchg_dcnt", dc8, 0);

        // HOLD mode ignores valids
        m8 = 2'd2; tick();
        v8 = 2'b11; tick(); v8 = '0;
        chk("hold_fcnt", fc8, 3);
        chk("hold_pend", p8, 0);

        // Layer sweep on both sizes, 20 pulses, HOLD=2
        rst_to(2'd0, 4'd3, 2'd0, 4'd3);
        tick();
        for (int k = 0; k < 20; k++) begin
            sd8 = 1'b1; sd4 = 1'b1; tick(); sd8 = 1'b0; sd4 = 1'b0;
            tick(); tick();
            e8 = '0; e8[((k/2)%8)*64 +: 64] = '1;
            e4 = '0; e4[((k/2)%4)*16 +: 16] = '1;
            chk($sformatf("layer8_%0d", k), q8, e8);
            chk($sformatf("layer4_%0d", k), q4, e4);
        end
        chk("static_fcnt8", fc8, 0);
        chk("static_dcnt8", dc8, 0);

        // x-plane sweep on N=4
        rst_to(2'd2, 4'd0, 2'd0, 4'd4);
        tick();
        for (int k = 0; k < 10; k++) begin
            sd4 = 1'b1; tick(); sd4 = 1'b0;
            tick(); tick();
            e4 = '0;
            for (int i = 0; i < 16; i++) e4[i*4 + (k/2)%4] = 1'b1;
            chk($sformatf("xplane4_%0d", k), q4, e4);
        end

        // Cube edges on N=4
        rst_to(2'd2, 4'd0, 2'd0, 4'd2);
        tick();
        sd4 = 1'b1; tick(); sd4 = 1'b0;
        chk("edges4", q4, 64'hF99F_9009_9009_F99F);

        // Overwrite on N=4 using highest legal source
        rst_to(2'd2, 4'd0, 2'd1, 4'd2);
        f4[2*FW4 +: FW4] = {8{8'hF1}}; v4 = 3'b100; tick();
        f4[2*FW4 +: FW4] = {8{8'hF2}}; tick(); v4 = '0;
        chk("ovw4_dcnt", dc4, 1);
        chk("ovw4_fcnt", fc4, 2);
        sd4 = 1'b1; tick(); sd4 = 1'b0;
        chk("ovw4_front", q4, {8{8'hF2}});

        // Source index beyond NSRC behaves as HOLD
        s4 = 4'd3; tick();
        v4 = 3'b111; tick(); v4 = '0;
        chk("oob4_fcnt", fc4, 2);
        chk("oob4_pend", p4, 0);
        chk("oob4_front", q4, {8{8'hF2}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
